// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: length header, MSB-first 16-bit words, sequential writes.
// Optional trailing 16-bit checksum stage when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, W_HI, W_LO, WRITE,
`ifdef INSTR_LOADER_CHECKSUM_EN
    CK_HI, CK_LO,
`endif
    DONE, ERR
  } state_t;

  // State entered once the last word (or an empty header) has been handled.
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t FIN = CK_HI;
`else
  localparam state_t FIN = DONE;
`endif

  state_t      state, nxt;
  logic [15:0] len;
  logic [15:0] n_hdr;
  logic        xfer;
  logic        ready_nxt;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [15:0] sum;
  logic [7:0]  ck_hi;
`endif

  assign xfer  = byte_valid && byte_ready;
  assign n_hdr = {len[15:8], byte_in};

  always_comb begin
    nxt       = state;
    ready_nxt = 1'b0;
    case (state)
      IDLE, DONE, ERR: if (start) nxt = LEN_HI;
      LEN_HI: if (xfer) nxt = LEN_LO;
      LEN_LO: if (xfer) begin
        if (n_hdr == 16'd0)                   nxt = FIN;
        else if (n_hdr > 16'(MAX_WORDS))      nxt = ERR;
        else                                  nxt = W_HI;
      end
      W_HI:  if (xfer) nxt = W_LO;
      W_LO:  if (xfer) nxt = WRITE;
      WRITE: nxt = (word_count + 16'd1 == len) ? FIN : W_HI;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CK_HI: if (xfer) nxt = CK_LO;
      CK_LO: if (xfer) nxt = ({ck_hi, byte_in} == sum) ? DONE : ERR;
`endif
      default: nxt = IDLE;
    endcase
    // byte_ready is a registered decode of the state being entered.
    case (nxt)
`ifdef INSTR_LOADER_CHECKSUM_EN
      CK_HI, CK_LO,
`endif
      LEN_HI, LEN_LO, W_HI, W_LO: ready_nxt = 1'b1;
      default:                    ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      word_count <= '0;
      len        <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum        <= '0;
      ck_hi      <= '0;
`endif
    end else begin
      state      <= nxt;
      byte_ready <= ready_nxt;
      wr_en      <= (nxt == WRITE);
      busy       <= !(nxt == IDLE || nxt == DONE || nxt == ERR);
      done       <= (nxt == DONE);
      err        <= (nxt == ERR);

      if ((state == IDLE || state == DONE || state == ERR) && start) begin
        word_count <= '0;
        wr_addr    <= BASE_ADDR;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum        <= '0;
`endif
      end

      if (xfer) begin
        case (state)
          LEN_HI: len[15:8]     <= byte_in;
          LEN_LO: len[7:0]      <= byte_in;
          W_HI:   wr_data[15:8] <= byte_in;
          W_LO:   wr_data[7:0]  <= byte_in;
`ifdef INSTR_LOADER_CHECKSUM_EN
          CK_HI:  ck_hi         <= byte_in;
`endif
          default: ;
        endcase
      end

      if (state == WRITE) begin
        word_count <= word_count + 16'd1;
        wr_addr    <= wr_addr + ADDR_W'(2);
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum        <= sum + wr_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a stream-level reference model.
module tb_instr_mem_loader;
  localparam int MAXW = 28;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid, byte_ready, wr_en, busy, done, err;
  logic [7:0]  byte_in;
  logic [15:0] wr_addr, wr_data, word_count;

  instr_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0]  stim[$];
  logic [31:0] wq[$], exp_w[$];
  int          exp_consumed, exp_wc;
  bit          exp_done, exp_err;

  // Every cycle with wr_en high is one write; a stretched pulse shows up as an extra entry.
  always @(negedge clk) if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});

  // Reference: interpret the byte stream directly.
  task automatic model();
    int n;
    logic [15:0] sum, w, c;
    exp_w.delete();
    n = int'({stim[0], stim[1]});
    sum = 16'h0; exp_done = 0; exp_err = 0;
    if (n > MAXW) begin
      exp_err = 1; exp_consumed = 2; exp_wc = 0;
    end else begin
      for (int k = 0; k < n; k++) begin
        w = {stim[2+2*k], stim[3+2*k]};
        exp_w.push_back({16'(2*k), w});
        sum = sum + w;
      end
      exp_wc = n; exp_consumed = 2 + 2*n;
`ifdef INSTR_LOADER_CHECKSUM_EN
      c = {stim[2+2*n], stim[3+2*n]};
      exp_consumed += 2;
      exp_done = (c == sum); exp_err = (c != sum);
`else
      c = 16'h0;
      exp_done = 1;
`endif
    end
  endtask

  // Header, n random words, checksum (optionally corrupted), then two junk bytes.
  task automatic build(input int n, input bit bad_ck);
    logic [15:0] sum, w;
    stim.delete(); sum = 16'h0;
    stim.push_back(8'(n >> 8)); stim.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      w = 16'($urandom);
      stim.push_back(w[15:8]); stim.push_back(w[7:0]);
      sum = sum + w;
    end
    if (bad_ck) sum = sum + 16'd1;
    stim.push_back(sum[15:8]); stim.push_back(sum[7:0]);
    stim.push_back(8'hEE); stim.push_back(8'h77);
  endtask

  // mode 0: valid every cycle, 1: valid toggling 1/0, 2: random valid.
  task automatic run_session(input int mode, input string tag);
    int i, pend, cyc;
    bit acc;
    model(); wq.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL %s start: busy=%b done=%b err=%b, want 1 0 0", tag, busy, done, err);
    end
    i = 0; pend = -1; cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (pend >= 0) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 16'((pend - 3) / 2 * 2) || byte_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s latency: wr_en=%b addr=%h ready=%b, want 1 %h 0", tag, wr_en, wr_addr,
                   byte_ready, 16'((pend - 3) / 2 * 2));
        end
        pend = -1;
      end
      if (done === 1'b1 || err === 1'b1) break;
      byte_valid = (i < stim.size()) && (mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom));
      byte_in    = (i < stim.size()) ? stim[i] : 8'h00;
      acc = byte_valid && byte_ready;
      @(posedge clk); cyc++;
      if (acc) begin
        if (i >= 3 && i % 2 == 1 && !exp_err && i <= 2*exp_wc + 1) pend = i;
        i++;
      end
    end
    byte_valid = 1'b0;
    checks++;
    if (cyc >= 2000) begin errors++; $display("FAIL %s timeout: cycles=%0d, limit 2000", tag, cyc); end
    checks++;
    if (i != exp_consumed) begin errors++; $display("FAIL %s consumed: %0d, want %0d", tag, i, exp_consumed); end
    checks++;
    if (done !== exp_done || err !== exp_err || busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s status: done=%b err=%b busy=%b ready=%b, want %b %b 0 0", tag, done, err, busy,
               byte_ready, exp_done, exp_err);
    end
    checks++;
    if (word_count !== 16'(exp_wc) || wr_addr !== 16'(2*exp_wc)) begin
      errors++;
      $display("FAIL %s count: wc=%0d addr=%h, want %0d %h", tag, word_count, wr_addr, exp_wc, 16'(2*exp_wc));
    end
    checks++;
    if (wq.size() != exp_w.size()) begin
      errors++; $display("FAIL %s writes: %0d, want %0d", tag, wq.size(), exp_w.size());
    end else begin
      foreach (exp_w[k]) begin
        checks++;
        if (wq[k] !== exp_w[k]) begin
          errors++; $display("FAIL %s write%0d: addr/data=%h, want %h", tag, k, wq[k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (byte_ready !== 0 || wr_en !== 0 || busy !== 0 || done !== 0 || err !== 0 ||
        wr_addr !== 16'h0 || wr_data !== 16'h0 || word_count !== 16'h0) begin
      errors++;
      $display("FAIL reset: ready=%b wr_en=%b busy=%b done=%b err=%b addr=%h data=%h wc=%h, want all 0",
               byte_ready, wr_en, busy, done, err, wr_addr, wr_data, word_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01, 8'h55};
    run_session(0, "basic");
  endtask

  task automatic test_oversize();
    stim = '{8'h00, 8'h1D, 8'h11, 8'h22, 8'h33, 8'h44};
    run_session(0, "oversize");
    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h99};
    run_session(0, "restart_empty");
  endtask

  task automatic test_mid_reset();
    int i, cyc;
    bit acc;
    wq.delete();
    stim = '{8'h00, 8'h01, 8'h12};
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    i = 0; cyc = 0;
    while (i < 3 && cyc < 50) begin
      byte_valid = 1'b1; byte_in = stim[i];
      acc = byte_ready;
      @(posedge clk); cyc++;
      if (acc) i++;
      @(negedge clk);
    end
    rst = 1'b1; byte_valid = 1'b1; byte_in = 8'h34;
    @(negedge clk);
    rst = 1'b0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (i != 3) begin errors++; $display("FAIL midrst feed: consumed %0d, want 3", i); end
    checks++;
    if (wq.size() != 0 || busy !== 0 || done !== 0 || err !== 0 || byte_ready !== 0 ||
        word_count !== 16'h0 || wr_addr !== 16'h0) begin
      errors++;
      $display("FAIL midrst state: writes=%0d busy=%b done=%b err=%b ready=%b wc=%0d addr=%h, want 0s",
               wq.size(), busy, done, err, byte_ready, word_count, wr_addr);
    end
  endtask

  task automatic test_gapped();
    stim = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h06, 8'hA5};
    run_session(1, "gapped");
  endtask

  task automatic test_checksum();
`ifdef INSTR_LOADER_CHECKSUM_EN
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02};
    run_session(0, "ck_bad");
    build(0, 1'b0);
    run_session(0, "ck_empty");
`endif
    build(5, 1'b0);
    run_session(1, "full_rate_toggle");
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      build($urandom_range(MAXW + 3, 0), ($urandom % 3) == 0);
      run_session(2, $sformatf("rand%0d", r));
    end
    build(MAXW, 1'b0);
    run_session(0, "max_words");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_oversize();
    test_mid_reset();
    test_gapped();
    test_checksum();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
